// File: rtl/branch_update_queue.sv
// Branch update queue: holds predicted branches in program order and, on each ROB
// commit, writes the saturated 2-bit counter back to the pattern table.
module branch_update_queue #(
    parameter int PATTERN_HISTORY_LEN = 12,
    parameter int DEPTH               = 8,
    parameter int CNT_W               = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           alloc_valid,
    input  logic [PATTERN_HISTORY_LEN-1:0] alloc_idx,
    input  logic [1:0]                     alloc_pred,
    output logic                           alloc_ready,
    input  logic                           commit_valid,
    input  logic                           commit_taken,
    input  logic                           flush,
    output logic                           branch_write,
    output logic [1:0]                     updated_val,
    output logic [PATTERN_HISTORY_LEN-1:0] control_idx,
    output logic [$clog2(DEPTH):0]         occupancy,
    output logic [CNT_W-1:0]               mispredict_count,
    output logic                           underflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [PATTERN_HISTORY_LEN-1:0] idx_mem [DEPTH];
    logic [1:0]                     pred_mem [DEPTH];

    logic [PTR_W-1:0]               head_q, head_d;
    logic [PTR_W-1:0]               tail_q, tail_d;
    logic [OCC_W-1:0]               occ_q, occ_d;
    logic                           bw_q, bw_d;
    logic [1:0]                     upd_q, upd_d;
    logic [PATTERN_HISTORY_LEN-1:0] cidx_q, cidx_d;
    logic [CNT_W-1:0]               mcnt_q, mcnt_d;
    logic                           uflow_q, uflow_d;

    logic                           alloc_acc;
    logic                           commit_acc;
    logic [1:0]                     head_pred;
    logic [PATTERN_HISTORY_LEN-1:0] head_idx;
    logic [1:0]                     new_val;

    assign alloc_ready = (occ_q != OCC_W'(DEPTH));
    assign alloc_acc   = alloc_valid && alloc_ready && !flush;
    assign commit_acc  = commit_valid && (occ_q != '0);
    assign head_pred   = pred_mem[head_q];
    assign head_idx    = idx_mem[head_q];

    always_comb begin
        new_val = head_pred;
        if (commit_taken) begin
            if (head_pred != 2'b11) new_val = head_pred + 2'd1;
        end else begin
            if (head_pred != 2'b00) new_val = head_pred - 2'd1;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        occ_d   = occ_q;
        bw_d    = 1'b1;
        upd_d   = upd_q;
        cidx_d  = cidx_q;
        mcnt_d  = mcnt_q;
        uflow_d = uflow_q;

        // A same-cycle commit is still written out even when flushing.
        if (commit_acc) begin
            bw_d   = 1'b0;
            upd_d  = new_val;
            cidx_d = head_idx;
            if ((head_pred[1] != commit_taken) && (mcnt_q != {CNT_W{1'b1}}))
                mcnt_d = mcnt_q + CNT_W'(1);
        end
        if (commit_valid && (occ_q == '0))
            uflow_d = 1'b1;

        if (flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            if (commit_acc) head_d = head_q + PTR_W'(1);
            if (alloc_acc)  tail_d = tail_q + PTR_W'(1);
            case ({alloc_acc, commit_acc})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            bw_q    <= 1'b1;
            upd_q   <= 2'b00;
            cidx_q  <= '0;
            mcnt_q  <= '0;
            uflow_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            bw_q    <= bw_d;
            upd_q   <= upd_d;
            cidx_q  <= cidx_d;
            mcnt_q  <= mcnt_d;
            uflow_q <= uflow_d;
        end
    end

    // Entry storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (alloc_acc) begin
            idx_mem[tail_q]  <= alloc_idx;
            pred_mem[tail_q] <= alloc_pred;
        end
    end

    assign branch_write     = bw_q;
    assign updated_val      = upd_q;
    assign control_idx      = cidx_q;
    assign occupancy        = occ_q;
    assign mispredict_count = mcnt_q;
    assign underflow_err    = uflow_q;

endmodule
